// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the fetch/data unified-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  // Counter increment that sticks at all-ones.
  function automatic logic [STARVE_CNT_W-1:0] sat_inc(input logic [STARVE_CNT_W-1:0] v);
    logic [STARVE_CNT_W-1:0] r;
    if (v == {STARVE_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(STARVE_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch (IF) and data (DM) ports onto one req/gnt/rvalid memory bus.
// Defining MEM_ARBITER_PERF_EN adds the perf_if_wait / perf_dm_wait stall counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [3:0]        dm_be,
  output logic [31:0]       dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_dm_wait
`endif
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_t               state_q, state_d;
  arb_owner_t               owner_q, owner_d;
  logic [STARVE_CNT_W-1:0]  starve_q, starve_d;
  logic                     discard_q, discard_d;
  logic                     mem_req_q, mem_req_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [31:0]              mem_wdata_q, mem_wdata_d;
  logic [3:0]               mem_be_q, mem_be_d;

  logic                     if_valid_s;
  logic                     grant_if_s;
  logic                     flush_own_s;
  logic                     if_ready_s;
  logic                     dm_ready_s;

  // A fetch flushed in the same cycle never competes for the bus.
  assign if_valid_s  = if_req && !if_flush;
  assign grant_if_s  = if_valid_s && (!dm_req || (starve_q >= LIMIT_C));
  assign flush_own_s = if_flush && (owner_q == OWN_IF);

  // Next-state, arbitration and completion decode.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    discard_d   = discard_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_ready_s  = 1'b0;
    dm_ready_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_valid_s || dm_req) begin
          state_d   = REQ;
          mem_req_d = 1'b1;
          discard_d = 1'b0;
          if (grant_if_s) begin
            owner_d     = OWN_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = 32'd0;
            mem_be_d    = 4'b1111;
            starve_d    = {STARVE_CNT_W{1'b0}};
          end else begin
            owner_d     = OWN_DM;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            mem_be_d    = dm_be;
            starve_d    = if_valid_s ? sat_inc(starve_q) : {STARVE_CNT_W{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          // A flush coinciding with the grant is handled as a flush in WAIT.
          state_d   = WAIT;
          mem_req_d = 1'b0;
          discard_d = flush_own_s;
        end else if (flush_own_s) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          if (owner_q == OWN_DM) begin
            dm_ready_s = 1'b1;
          end else begin
            if_ready_s = !(discard_q || if_flush);
          end
        end else if (flush_own_s) begin
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and bus-register update; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= {STARVE_CNT_W{1'b0}};
      discard_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      discard_q   <= discard_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

  assign if_ready  = if_ready_s;
  assign dm_ready  = dm_ready_s;
  assign if_rdata  = if_ready_s ? mem_rdata : 32'd0;
  assign dm_rdata  = dm_ready_s ? mem_rdata : 32'd0;

`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] perf_if_q;
  logic [31:0] perf_dm_q;

  // Saturating count of cycles each port spends requesting without completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_q <= 32'd0;
      perf_dm_q <= 32'd0;
    end else begin
      if (if_req && !if_ready_s && (perf_if_q != 32'hFFFF_FFFF)) begin
        perf_if_q <= perf_if_q + 32'd1;
      end
      if (dm_req && !dm_ready_s && (perf_dm_q != 32'hFFFF_FFFF)) begin
        perf_dm_q <= perf_dm_q + 32'd1;
      end
    end
  end

  assign perf_if_wait = perf_if_q;
  assign perf_dm_wait = perf_dm_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int LIMIT = 4;
  localparam int AW    = 32;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dm_op_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
  } grant_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0, if_flush = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [31:0]   if_rdata;
  logic          if_ready;
  logic          dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [31:0]   dm_wdata = '0;
  logic [3:0]    dm_be = '0;
  logic [31:0]   dm_rdata;
  logic          dm_ready;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;
`ifdef MEM_ARBITER_PERF_EN
  logic [31:0]   perf_if_wait, perf_dm_wait;
  logic [31:0]   pm_if = '0, pm_dm = '0;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MEM_ARBITER_PERF_EN
    , .perf_if_wait(perf_if_wait), .perf_dm_wait(perf_dm_wait)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Transaction-level model: at most one outstanding bus transaction.
  bit          m_busy, m_port, m_granted, m_discard;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  int          m_starve;
  bit          e_mem_req, e_if_rdy, e_dm_rdy;

  logic [31:0] if_q[$];
  dm_op_t      dm_q[$];
  bit          if_done, dm_done, if_flushed, dm_b2b;
  int          if_pct = 100, dm_pct = 100, flush_pct = 0, gnt_pct = 100;
  int          rsp_min = 0, rsp_max = 0, gnt_block = 0, rsp_cnt = 0;
  bit          fixed_rdata_en = 1'b0, flush_arm = 1'b0, flush_done = 1'b0, force_rvalid = 1'b0;
  logic [31:0] fixed_rdata = '0;

  grant_t      glog[$];
  int          if_rdy_n, dm_rdy_n, if_rdy_cyc, dm_rdy_cyc;
  logic [31:0] if_rdata_seen;
  bit          prev_mem_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic grant_t gl(input int i);
    if (i < glog.size()) return glog[i];
    return '0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_port = 0; m_granted = 0; m_discard = 0; m_starve = 0;
    rsp_cnt = 0; if_done = 0; dm_done = 0; if_flushed = 0;
`ifdef MEM_ARBITER_PERF_EN
    pm_if = '0; pm_dm = '0;
`endif
  endtask

  task automatic clear_logs();
    glog.delete(); if_rdy_n = 0; dm_rdy_n = 0; if_rdy_cyc = -1; dm_rdy_cyc = -1;
    if_rdata_seen = '0;
  endtask

  task automatic drive();
    dm_op_t op;
    if_flush = 1'b0;
    if (!rst) begin
      if_req = 0; dm_req = 0; mem_gnt = 0; mem_rvalid = 0;
      if_q.delete(); dm_q.delete();
    end else begin
      if (if_done || if_flushed) begin
        if (if_flushed && if_q.size() > 0) begin
          if_req = 1; if_addr = if_q.pop_front();
        end else begin
          if_req = 0;
        end
      end else if (!if_req && if_q.size() > 0 && int'($urandom_range(99)) < if_pct) begin
        if_req = 1; if_addr = if_q.pop_front();
      end
      if (flush_arm && m_busy && m_granted && m_port == 0 && rsp_cnt > 0) begin
        if_flush = 1; flush_arm = 0; flush_done = 1;
      end else if (flush_pct > 0 && (if_req || (m_busy && m_port == 0)) &&
                   int'($urandom_range(99)) < flush_pct) begin
        if_flush = 1;
      end
      if (dm_done) begin
        if (dm_b2b && dm_q.size() > 0) begin
          op = dm_q.pop_front(); dm_req = 1;
          dm_we = op.we; dm_addr = op.addr; dm_wdata = op.wdata; dm_be = op.be;
        end else begin
          dm_req = 0;
        end
      end else if (!dm_req && dm_q.size() > 0 && int'($urandom_range(99)) < dm_pct) begin
        op = dm_q.pop_front(); dm_req = 1;
        dm_we = op.we; dm_addr = op.addr; dm_wdata = op.wdata; dm_be = op.be;
      end
      mem_gnt = 0;
      if (m_busy && !m_granted) begin
        if (gnt_block > 0) gnt_block--;
        else mem_gnt = int'($urandom_range(99)) < gnt_pct;
      end
      mem_rvalid = force_rvalid || (m_busy && m_granted && rsp_cnt == 0);
    end
    mem_rdata = fixed_rdata_en ? fixed_rdata : $urandom();
  endtask

  task automatic check();
    chk("mem_req", {31'd0, mem_req}, {31'd0, e_mem_req});
    chk("if_ready", {31'd0, if_ready}, {31'd0, e_if_rdy});
    chk("dm_ready", {31'd0, dm_ready}, {31'd0, e_dm_rdy});
    if (!rst) begin
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_we_be", {27'd0, mem_we, mem_be}, 32'd0);
      chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    end
    if (e_mem_req) begin
      chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
      chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      if (m_port) chk("mem_be", {28'd0, mem_be}, {28'd0, m_be});
    end
    if (e_if_rdy) chk("if_rdata", if_rdata, mem_rdata);
    if (e_dm_rdy && !m_we) chk("dm_rdata", dm_rdata, mem_rdata);
`ifdef MEM_ARBITER_PERF_EN
    chk("perf_if_wait", perf_if_wait, pm_if);
    chk("perf_dm_wait", perf_dm_wait, pm_dm);
`endif
  endtask

  task automatic update();
    bit ifv, pick_if;
    if (!rst) begin
      model_reset();
      return;
    end
`ifdef MEM_ARBITER_PERF_EN
    if (if_req && !e_if_rdy && pm_if != 32'hFFFF_FFFF) pm_if++;
    if (dm_req && !e_dm_rdy && pm_dm != 32'hFFFF_FFFF) pm_dm++;
`endif
    if_done = e_if_rdy; dm_done = e_dm_rdy; if_flushed = if_flush;
    if (m_busy && !m_granted && mem_gnt) rsp_cnt = int'($urandom_range(rsp_max, rsp_min));
    else if (m_busy && m_granted && !mem_rvalid && rsp_cnt > 0) rsp_cnt--;
    if (!m_busy) begin
      ifv = if_req && !if_flush;
      if (ifv || dm_req) begin
        pick_if = ifv && (!dm_req || m_starve >= LIMIT);
        m_busy = 1; m_granted = 0; m_discard = 0;
        if (pick_if) begin
          m_port = 0; m_we = 0; m_addr = if_addr; m_starve = 0;
        end else begin
          m_port = 1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_be = dm_be;
          m_starve = ifv ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
        end
      end
    end else if (!m_granted) begin
      if (mem_gnt) begin
        m_granted = 1; m_discard = (m_port == 0) && if_flush;
      end else if (m_port == 0 && if_flush) begin
        m_busy = 0;
      end
    end else if (mem_rvalid) begin
      m_busy = 0; m_discard = 0;
    end else if (m_port == 0 && if_flush) begin
      m_discard = 1;
    end
  endtask

  // One clock cycle: drive at edge+1, check at edge+3, advance the model on the edge.
  task automatic cycle();
    drive();
    #2;
    e_mem_req = rst && m_busy && !m_granted;
    e_if_rdy  = rst && m_busy && m_granted && mem_rvalid && m_port == 0 && !(m_discard || if_flush);
    e_dm_rdy  = rst && m_busy && m_granted && mem_rvalid && m_port == 1;
    check();
    if (mem_req && !prev_mem_req) glog.push_back(grant_t'{mem_we, mem_addr});
    prev_mem_req = mem_req;
    if (if_ready) begin if_rdy_n++; if_rdy_cyc = cyc; if_rdata_seen = if_rdata; end
    if (dm_ready) begin dm_rdy_n++; dm_rdy_cyc = cyc; end
    @(posedge clk);
    update();
    cyc++;
    #1;
  endtask

  task automatic run_idle(input int limit, input string name);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!(!m_busy && !if_req && !dm_req && if_q.size() == 0 && dm_q.size() == 0) && n < limit);
    if (n >= limit) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout after %0d cycles", name, n);
    end
  endtask

  initial begin
    int t0;
    dm_op_t op;
`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] p0;
`endif
    model_reset();
    clear_logs();
    prev_mem_req = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_ready", {30'd0, if_ready, dm_ready}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    rst = 1;

    // Single fetch: ready two cycles after the request.
    fixed_rdata_en = 1; fixed_rdata = 32'h0050_0093;
    clear_logs(); t0 = cyc;
    if_q.push_back(32'h0000_0010);
    run_idle(20, "single_fetch");
    chk("t1_latency", if_rdy_cyc - t0, 32'd2);
    chk("t1_rdata", if_rdata_seen, 32'h0050_0093);
    chk("t1_bus_addr", gl(0).addr, 32'h10);
    chk("t1_bus_we", {31'd0, gl(0).we}, 32'd0);
    fixed_rdata_en = 0;

    // Collision: store wins first, fetch follows.
    clear_logs(); t0 = cyc;
    if_q.push_back(32'h0000_0020);
    dm_q.push_back(dm_op_t'{1'b1, 32'h100, 32'hDEAD_BEEF, 4'b1111});
    run_idle(30, "collision");
    chk("t2_first_addr", gl(0).addr, 32'h100);
    chk("t2_first_we", {31'd0, gl(0).we}, 32'd1);
    chk("t2_second_addr", gl(1).addr, 32'h20);
    chk("t2_dm_cyc", dm_rdy_cyc - t0, 32'd2);
    chk("t2_if_cyc", if_rdy_cyc - t0, 32'd5);

    // Starvation: four back-to-back DM wins, then IF.
    clear_logs(); dm_b2b = 1;
    for (int i = 0; i < 6; i++) dm_q.push_back(dm_op_t'{1'b0, 32'h400 + 32'(4 * i), 32'd0, 4'hF});
    if_q.push_back(32'h0000_0030);
    run_idle(60, "starvation");
    chk("t3_grants", glog.size(), 32'd7);
    chk("t3_g3_addr", gl(3).addr, 32'h40C);
    chk("t3_g4_addr", gl(4).addr, 32'h30);
    chk("t3_g5_addr", gl(5).addr, 32'h410);
    dm_b2b = 0;

    // Flush while the fetch waits for its response.
    clear_logs(); rsp_min = 2; rsp_max = 2; flush_arm = 1; flush_done = 0;
    if_q.push_back(32'h0000_0040);
    for (int i = 0; i < 20 && !(flush_done && !m_busy); i++) cycle();
    dm_q.push_back(dm_op_t'{1'b0, 32'h200, 32'd0, 4'b0011});
    run_idle(20, "flush_wait");
    chk("t4_flush_seen", {31'd0, flush_done}, 32'd1);
    chk("t4_if_ready_n", if_rdy_n, 32'd0);
    chk("t4_dm_ready_n", dm_rdy_n, 32'd1);
    chk("t4_dm_addr", gl(1).addr, 32'h200);
    rsp_min = 0; rsp_max = 0; flush_arm = 0;

    // Grant backpressure, then reset in the middle of REQ.
    clear_logs(); gnt_block = 5;
    if_q.push_back(32'h0000_0080);
    cycle();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_hold_req", {31'd0, mem_req}, 32'd1);
      chk("t5_hold_addr", mem_addr, 32'h80);
      cycle();
    end
    #1;
    rst = 0;
    model_reset();
    #1;
    chk("t5_async_req", {31'd0, mem_req}, 32'd0);
    chk("t5_async_addr", mem_addr, 32'd0);
    chk("t5_async_we_be", {27'd0, mem_we, mem_be}, 32'd0);
    cycle();
    rst = 1; gnt_block = 0;
    force_rvalid = 1;
    cycle();
    force_rvalid = 0;
    cycle();
    chk("t5_stray_ready", if_rdy_n + dm_rdy_n, 32'd0);
    chk("t5_idle_req", {31'd0, mem_req}, 32'd0);

`ifdef MEM_ARBITER_PERF_EN
    clear_logs(); gnt_block = 3; p0 = perf_if_wait;
    if_q.push_back(32'h0000_0090);
    run_idle(20, "perf_fetch");
    chk("t6_perf_if", perf_if_wait - p0, 32'd5);
`endif

    // Randomized traffic in phases of varying load.
    if_pct = 60; dm_pct = 50; flush_pct = 4; gnt_pct = 60; rsp_min = 0; rsp_max = 3;
    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 0) begin
        dm_b2b  = 1'($urandom_range(1));
        dm_pct  = (i % 500 == 0) ? 100 : 40;
        gnt_pct = int'($urandom_range(100, 30));
      end
      if (if_q.size() < 2) if_q.push_back($urandom() & 32'hFFFF_FFFC);
      if (dm_q.size() < 2) begin
        op.we = 1'($urandom_range(1)); op.addr = $urandom(); op.wdata = $urandom();
        op.be = 4'($urandom_range(15));
        dm_q.push_back(op);
      end
      cycle();
    end
    flush_pct = 0; if_q.delete(); dm_q.delete();
    run_idle(100, "drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the fetch port (IF) and the data-memory port (DM) of the pipelined core onto one single-ported unified memory bus with a req/gnt/rvalid handshake.
- Sits between the pipeline's fetch and memory stages and the memory model.
- Returns a per-port ready pulse. The hazard logic stalls the stage whose request is still pending.
- Bounds fetch starvation, and supports squashing an in-flight fetch on a branch or jump.

Parameters:
- STARVE_LIMIT, 4: consecutive IF losses to DM after which IF wins the next arbitration. Range 1..15.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_flush  in  1  squash the pending or in-flight fetch (PCSrc redirect).
- if_rdata  out  32  fetched instruction; valid with if_ready.
- if_ready  out  1  one-cycle completion pulse for IF.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  32  store data.
- dm_be  in  4  byte enables (AddressingControl-derived).
- dm_rdata  out  32  load data; valid with dm_ready.
- dm_ready  out  1  one-cycle completion pulse for DM.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  bus write enable.
- mem_addr  out  ADDR_W  bus address.
- mem_wdata  out  32  bus write data.
- mem_be  out  4  bus byte enables.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  response valid (load data or write ack).
- mem_rdata  in  32  response data.

Behaviour:
- Reset (rst=0, async): state=IDLE; owner=IF; starve_cnt=0; discard=0; all mem_* outputs, if_ready, dm_ready and rdata outputs are 0. A transaction abandoned by reset is not retried, and a late mem_rvalid in IDLE is ignored.
- FSM: IDLE -> REQ -> WAIT -> IDLE.
- IDLE:
  - If any unflushed request is present, latch owner and the request fields into mem_* registers. Next state is REQ and mem_req=1.
  - Priority: DM wins, except IF wins when starve_cnt >= STARVE_LIMIT.
  - if_req with if_flush high in the same cycle is not an IF request.
- REQ: mem_req held high and mem_* held stable until mem_gnt; then WAIT, mem_req=0.
  - if_flush while owner=IF and no mem_gnt: drop mem_req, go to IDLE, no if_ready.
  - if_flush in the same cycle as mem_gnt: treated as flush during WAIT.
- WAIT: on mem_rvalid, pulse the owner's ready combinationally in that cycle with rdata passed through from mem_rdata; go to IDLE.
  - Writes also complete on mem_rvalid; rdata is don't-care.
  - if_flush while owner=IF in WAIT sets discard. The matching mem_rvalid is swallowed (no if_ready) and discard clears.
  - if_flush with owner=DM has no effect.
- Minimum latency: request at cycle 0 -> mem_req at cycle 1 -> ready at cycle 2 (gnt at 1, rvalid at 2). One transaction outstanding at a time.
- Requesters drop req the cycle after ready. Since the next arbitration happens in IDLE one cycle after the ready pulse, back-to-back requests are not double-counted.
- starve_cnt:
  - +1 (saturating at 15) on each arbitration DM wins while if_req is pending.
  - Cleared when IF is granted or if_req is low at arbitration.
- Idle-cycle rule: ready outputs are 0 in every cycle other than the completion cycle.

Optional Feature:
- Macro: MEM_ARBITER_PERF_EN.
- Defined: adds outputs perf_if_wait[31:0] and perf_dm_wait[31:0]. Each counts cycles in which that port's req is high and its ready is low. Both saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, REQ, WAIT};
  - arb_owner_t enum {OWN_IF, OWN_DM};
  - localparam STARVE_CNT_W = 4.
- No sub-module; a single flat module.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0010; memory gnt at once, rvalid next cycle with 0x0050_0093 -> if_ready pulses at cycle 2 with if_rdata=0x0050_0093; mem_we=0.
- Collision: if_req and dm_req (store, addr 0x100, wdata 0xDEAD_BEEF, be=4'b1111) both high in IDLE -> DM served first (mem_we=1, mem_addr=0x100), then IF; dm_ready precedes if_ready.
- Starvation: dm_req held high continuously with STARVE_LIMIT=4 and if_req high -> after 4 DM grants, the 5th grant goes to IF and starve_cnt returns to 0.
- Flush in WAIT: IF granted, if_flush pulsed before rvalid -> rvalid swallowed, no if_ready; a following dm_req is served normally.
- Gnt backpressure and reset: hold mem_gnt=0 for 3 cycles -> mem_req and mem_addr stable throughout. Assert rst=0 mid-REQ -> all outputs 0 immediately (async); after release the FSM is in IDLE and ignores a stray mem_rvalid.
- With MEM_ARBITER_PERF_EN: single fetch with a 3-cycle gnt delay -> perf_if_wait=5.
